// File: rtl/scan_search_ctrl_if.sv
// Bundle between the scan sequencer, its controlling FSM and the shared read-only memory.
// Handshakes: start is taken only while the sequencer is idle or done (done is the level ack, held until the next
// accepted start); mem_rd_en is a one-cycle request, answered later by one cycle of mem_rd_valid with mem_rd_data.
interface scan_search_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int SUM_W  = 12
);
  logic              start;
  logic [DATA_W-1:0] key;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] found_index;
  logic [SUM_W-1:0]  sum;
  logic              sum_ovf;
  logic              timeout_err;

  modport slave (
    input  start, key, base, len, mem_rd_data, mem_rd_valid,
    output mem_rd_en, mem_addr, busy, done, found, found_index, sum, sum_ovf, timeout_err
  );

  modport master (
    output start, key, base, len, mem_rd_data, mem_rd_valid,
    input  mem_rd_en, mem_addr, busy, done, found, found_index, sum, sum_ovf, timeout_err
  );
endinterface

// File: rtl/scan_search_ctrl.sv
// Scans len words from base (wrapping) for key, summing every scanned word; stops on first match,
// end of array, or a read that never returns within TIMEOUT cycles.
module scan_search_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int SUM_W   = 12,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  scan_search_ctrl_if.slave   bus,
  output logic [2:0]          o_dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_key;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [DATA_W-1:0] r_data;
  logic [SUM_W-1:0]  r_sum;
  logic              r_sum_ovf;
  logic              r_found;
  logic [ADDR_W-1:0] r_found_index;
  logic              r_timeout_err;

  logic              w_start_ok;
  logic [ADDR_W:0]   w_idx_next;
  logic [CNT_W-1:0]  w_wait_next;
  logic [SUM_W:0]    w_sum_ext;
  logic              w_hit;

  assign w_start_ok  = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_idx_next  = r_idx + 1'b1;
  assign w_wait_next = r_wait_cnt + 1'b1;
  // Extra top bit of the widened add is the carry that marks a wrap of the accumulator.
  assign w_sum_ext   = {1'b0, r_sum} + {{(SUM_W + 1 - DATA_W){1'b0}}, r_data};
  assign w_hit       = (r_data == r_key);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_key         <= '0;
      r_base        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_wait_cnt    <= '0;
      r_data        <= '0;
      r_sum         <= '0;
      r_sum_ovf     <= 1'b0;
      r_found       <= 1'b0;
      r_found_index <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_key         <= bus.key;
            r_base        <= bus.base;
            r_len         <= bus.len;
            r_idx         <= '0;
            r_sum         <= '0;
            r_sum_ovf     <= 1'b0;
            r_found       <= 1'b0;
            r_found_index <= '0;
            r_timeout_err <= 1'b0;
            r_state       <= (bus.len == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_rd_valid) begin
            r_data  <= bus.mem_rd_data;
            r_state <= S_CHECK;
          end else begin
            r_wait_cnt <= w_wait_next;
            if (w_wait_next == CNT_W'(TIMEOUT)) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_DONE;
            end
          end
        end
        S_CHECK: begin
          r_sum <= w_sum_ext[SUM_W-1:0];
          if (w_sum_ext[SUM_W]) r_sum_ovf <= 1'b1;
          if (w_hit) begin
            r_found       <= 1'b1;
            r_found_index <= r_idx[ADDR_W-1:0];
            r_state       <= S_DONE;
          end else begin
            r_idx   <= w_idx_next;
            r_state <= (w_idx_next == r_len) ? S_DONE : S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the registered state, so they are glitch-free and drop right after reset.
  assign bus.mem_rd_en   = (r_state == S_ISSUE);
  assign bus.mem_addr    = r_base + r_idx[ADDR_W-1:0];
  assign bus.busy        = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CHECK);
  assign bus.done        = (r_state == S_DONE);
  assign bus.found       = r_found;
  assign bus.found_index = r_found_index;
  assign bus.sum         = r_sum;
  assign bus.sum_ovf     = r_sum_ovf;
  assign bus.timeout_err = r_timeout_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_scan_search_ctrl.sv
// Bench for scan_search_ctrl: memory responder with variable latency, reference search model,
// directed cases followed by randomized scans.
module tb_scan_search_ctrl;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int SUM_W   = 8;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int MAXC    = 600;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  scan_search_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) bus ();

  scan_search_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bench state ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  int                lat_q[$];
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] got_q[$];
  int                busy_cyc;
  int                rsp_rem;
  logic [ADDR_W-1:0] rsp_addr;
  logic              never_pending;
  logic              noise_en;
  int                n_checks = 0;
  int                n_errors = 0;

  logic              m_found;
  int                m_idx;
  int                m_sum;
  logic              m_ovf;
  logic              m_tmo;
  int                m_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    rsp_rem          = 0;
    rsp_addr         = '0;
    never_pending    = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = DATA_W'($urandom_range(0, 255));
      if (rsp_rem > 0) begin
        rsp_rem--;
        if (rsp_rem == 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = mem[rsp_addr];
        end
      end
      if (bus.mem_rd_en === 1'b1) begin
        int l;
        rsp_addr = bus.mem_addr;
        l = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        if (l == 0) never_pending = 1'b1;
        else rsp_rem = l;
      end
      // Stray valid pulses while no read is outstanding must be ignored by the sequencer.
      if (noise_en && rsp_rem == 0 && !never_pending && !bus.mem_rd_valid && $urandom_range(0, 3) == 0)
        bus.mem_rd_valid = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.mem_rd_en === 1'b1) got_q.push_back(bus.mem_addr);
    end
  end

  // ---------------- reference model ----------------
  // lat_mode: 0 = read never answered, 1 = answer next cycle, 2 = random 1..5 cycles.
  task automatic ref_model(input logic [DATA_W-1:0] k, input int b, input int l, input int lat_mode);
    int s;
    int lat;
    s = 0; m_found = 0; m_idx = 0; m_ovf = 0; m_tmo = 0; m_cyc = 0;
    exp_q.delete();
    lat_q.delete();
    for (int i = 0; i < l; i++) begin
      int a;
      a = (b + i) % DEPTH;
      exp_q.push_back(ADDR_W'(a));
      if (lat_mode == 0) begin
        lat_q.push_back(0);
        m_tmo = 1;
        m_cyc = 1 + TIMEOUT;
        break;
      end
      lat = (lat_mode == 1) ? 1 : $urandom_range(1, 5);
      lat_q.push_back(lat);
      m_cyc += 2 + lat;
      s += mem[a];
      if (s >= (1 << SUM_W)) begin
        s -= (1 << SUM_W);
        m_ovf = 1;
      end
      if (mem[a] == k) begin
        m_found = 1;
        m_idx = i;
        break;
      end
    end
    m_sum = s;
  endtask

  // ---------------- driver ----------------
  task automatic run_scan(input string nm, input logic [DATA_W-1:0] k, input int b, input int l,
                          input int lat_mode, input int hold);
    int cyc;
    ref_model(k, b, l, lat_mode);
    @(negedge clk);
    never_pending = 1'b0;
    rsp_rem = 0;
    got_q.delete();
    busy_cyc = 0;
    bus.start = 1'b1;
    bus.key   = k;
    bus.base  = ADDR_W'(b);
    bus.len   = (ADDR_W + 1)'(l);
    @(negedge clk);
    for (int h = 0; h < hold; h++) begin
      bus.key  = DATA_W'($urandom_range(0, 255));
      bus.base = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.len  = (ADDR_W + 1)'($urandom_range(1, DEPTH));
      @(negedge clk);
    end
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < MAXC) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, ":done"}, bus.done, 1);
    if (l == 0) check({nm, ":len0_latency"}, cyc, 0);
    check({nm, ":busy"}, bus.busy, 0);
    check({nm, ":found"}, bus.found, m_found);
    check({nm, ":found_index"}, bus.found_index, m_idx);
    check({nm, ":sum"}, bus.sum, m_sum);
    check({nm, ":sum_ovf"}, bus.sum_ovf, m_ovf);
    check({nm, ":timeout_err"}, bus.timeout_err, m_tmo);
    check({nm, ":busy_cycles"}, busy_cyc, m_cyc);
    check({nm, ":n_reads"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({nm, ":addr"}, got_q.pop_front(), exp_q.pop_front());
    repeat (3) @(negedge clk);
    check({nm, ":done_hold"}, bus.done, 1);
    check({nm, ":sum_hold"}, bus.sum, m_sum);
    check({nm, ":rd_en_idle"}, bus.mem_rd_en, 0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ":busy"}, bus.busy, 0);
    check({nm, ":done"}, bus.done, 0);
    check({nm, ":rd_en"}, bus.mem_rd_en, 0);
    check({nm, ":addr"}, bus.mem_addr, 0);
    check({nm, ":found"}, bus.found, 0);
    check({nm, ":found_index"}, bus.found_index, 0);
    check({nm, ":sum"}, bus.sum, 0);
    check({nm, ":sum_ovf"}, bus.sum_ovf, 0);
    check({nm, ":timeout_err"}, bus.timeout_err, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nrd;
    int b;
    int l;
    logic [DATA_W-1:0] k;
    reset = 1'b1;
    noise_en = 1'b0;
    bus.start = 1'b0;
    bus.key = '0;
    bus.base = '0;
    bus.len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(100, 255));
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) mem[i] = DATA_W'(10 * (i + 1));
    run_scan("find40", 8'd40, 0, 8, 1, 0);
    run_scan("miss99", 8'd99, 0, 4, 1, 0);
    mem[14] = 8'd1; mem[15] = 8'd2; mem[0] = 8'd3; mem[1] = 8'd4;
    run_scan("wrap", 8'd4, 14, 4, 1, 0);
    run_scan("len0", 8'd3, 5, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);
    run_scan("start_held", 8'd200, 2, 4, 2, 5);
    run_scan("timeout", 8'd5, 0, 3, 0, 0);
    run_scan("after_tmo", 8'd3, 0, 6, 2, 0);
    mem[0] = 8'hFF; mem[1] = 8'h02;
    run_scan("ovf", 8'h55, 0, 2, 1, 0);

    // Reset in the middle of a stalled read, after two 0xFF words have wrapped the sum.
    for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
    lat_q.delete();
    lat_q.push_back(1); lat_q.push_back(1); lat_q.push_back(0);
    @(negedge clk);
    never_pending = 1'b0;
    rsp_rem = 0;
    bus.start = 1'b1; bus.key = 8'h00; bus.base = '0; bus.len = 5'd8;
    @(negedge clk);
    bus.start = 1'b0;
    nrd = (bus.mem_rd_en === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40 && nrd < 3; c++) begin
      @(negedge clk);
      if (bus.mem_rd_en === 1'b1) nrd++;
    end
    @(negedge clk);
    check("pre_reset:busy", bus.busy, 1);
    check("pre_reset:sum", bus.sum, 8'hFE);
    check("pre_reset:sum_ovf", bus.sum_ovf, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    never_pending = 1'b0;
    lat_q.delete();

    noise_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 255));
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, DEPTH);
      if (l > 0 && $urandom_range(0, 1) == 1) k = mem[(b + $urandom_range(0, l - 1)) % DEPTH];
      else k = DATA_W'($urandom_range(0, 255));
      run_scan("rand", k, b, l, 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/scan_search_ctrl.md
Name: scan_search_ctrl

Overview:
Sequencer that scans a word array in a shared read-only memory for a key and accumulates the sum of every word it scans. It stops on the first match or at the end of the array. It issues memory reads, waits for read data and decides when the scan is complete. A start/done handshake connects it to the top-level control FSM, and it drives the sum/index/found result registers.

Parameters:
DATA_W, 8, width of memory words and key
ADDR_W, 4, memory address width; also the width of the index and length
SUM_W, 12, accumulator width
TIMEOUT, 15, maximum cycles spent in WAIT before aborting (must be >= 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a scan; sampled only in IDLE or DONE
key  in  DATA_W  search key, latched on an accepted start
base  in  ADDR_W  first address, latched on an accepted start
len  in  ADDR_W+1  number of words to scan (0..2^ADDR_W), latched on an accepted start
mem_rd_en  out  1  one-cycle read strobe
mem_addr  out  ADDR_W  read address, valid while mem_rd_en=1
mem_rd_data  in  DATA_W  read data
mem_rd_valid  in  1  read data valid
busy  out  1  high in ISSUE/WAIT/CHECK
done  out  1  high (level) while in DONE
found  out  1  key matched
found_index  out  ADDR_W  offset (from base) of the first match
sum  out  SUM_W  sum of the words scanned
sum_ovf  out  1  sticky flag: accumulator wrapped during this scan
timeout_err  out  1  scan aborted by WAIT timeout

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE. All outputs 0. Internal index/counters 0. Reset has priority over every other input, including mid-scan: mem_rd_en is low from the first cycle after the reset edge.
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE with start=1:
  - latch key/base/len; clear sum, sum_ovf, found, found_index, timeout_err; set idx=0.
  - next state = DONE if len==0 (all results 0), else ISSUE.
- start is ignored in ISSUE/WAIT/CHECK.
- DONE with start=0: stay in DONE and hold all results; done=1.
- ISSUE:
  - mem_rd_en=1 for exactly this cycle.
  - mem_addr = (base+idx) mod 2^ADDR_W, so addresses wrap past the top.
  - clear the wait counter; next state = WAIT.
- WAIT:
  - if mem_rd_valid=1: capture mem_rd_data; next state = CHECK.
  - otherwise increment the wait counter; when it reaches TIMEOUT, set timeout_err=1 and go to DONE.
  - mem_rd_valid is ignored in every state other than WAIT.
  - minimum latency: valid in the cycle after ISSUE, giving ISSUE→WAIT→CHECK = 3 cycles per word.
- CHECK:
  - sum <= sum + zero-extended data, modulo 2^SUM_W; set sum_ovf if a carry out occurs.
  - the matching word is included in sum.
  - if data==key: found=1, found_index=idx, go to DONE.
  - else idx++; if idx==len go to DONE, else go to ISSUE.
- Outputs are registered; found/sum update on the CHECK→next edge.
- done rises on the same edge as entry to DONE and stays high until a start is accepted.

Test Plan:
- Memory[0..7]=10,20,30,40,50,60,70,80, base=0, len=8, key=40, 1-cycle valid -> found=1, found_index=3, sum=100, done after 12 cycles in the scan states, exactly 4 mem_rd_en pulses.
- Same memory, key=99, len=4 -> found=0, sum=100, 4 reads at addresses 0..3, done=1 held.
- base=14, len=4, memory[14,15,0,1]=1,2,3,4, key=4 -> addresses 14,15,0,1; found_index=3; sum=10.
- len=0, start -> DONE on the next cycle, no mem_rd_en, all results 0. Also: start held high during a scan -> no restart, len unchanged.
- mem_rd_valid never asserted, TIMEOUT=15 -> timeout_err=1 and done=1 after 15 WAIT cycles; a subsequent start clears timeout_err.
- reset asserted in WAIT with 0xFF words and SUM_W=8 partially summed -> next cycle IDLE, all outputs 0, mem_rd_en=0. Separately, summing 0xFF,0x02 with SUM_W=8 -> sum=0x01, sum_ovf=1.
